generic_iob: RTL and testbench

GENERIC_IOB -- requirements
Module: generic_iob

---
 rtl/generic_iob_if.sv | 11 +
 rtl/generic_iob.sv | 114 +++++++++++
 tb/tb_generic_iob.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_iob_if.sv
// generic_iob_if: core-side signals of a single-bit pad cell.
// The core (master) supplies drive data I and enable OE and receives the
// pad level O; the pad cell (slave) sees the opposite directions.
interface generic_iob_if;
    logic I;   // core data to drive onto the pad
    logic OE;  // output enable, 1 = drive the pad
    logic O;   // pad level delivered to the core

    modport master (output I, output OE, input  O);
    modport slave  (input  I, input  OE, output O);
endinterface

// File: rtl/generic_iob.sv
// generic_iob: single-bit bidirectional pad cell.
//
// Output path: I/OE drive PAD either combinationally or through one clock
// register that holds the pair {OE, I} as a single word. Input path: PAD is
// returned to the core on O either combinationally or through one capture flop.
//
// Build option: define GENERIC_IOB_SYNC_EN to place a two-flop synchroniser
// (reset to IN_RST_VAL) in front of the input path. The input latency is then
// 2 + INPUT_REG cycles instead of INPUT_REG.
//
// No pull-ups and no drive-strength control; the only state is the output
// register, the optional synchroniser and the optional input flop.
module generic_iob #(
    parameter bit INPUT_USED  = 1'b1,  // instantiate the pad-to-core path
    parameter bit OUTPUT_USED = 1'b1,  // instantiate the core-to-pad driver
    parameter bit INPUT_REG   = 1'b0,  // register the input path on clk
    parameter bit OUTPUT_REG  = 1'b0,  // register {OE, I} on clk before PAD
    parameter bit IN_RST_VAL  = 1'b0   // reset value of every input-path flop
) (
    input  logic         clk,
    input  logic         rst_n,
    generic_iob_if.slave core,
    inout  wire          PAD
);

    // Enable and data travel as one word, so they can only be registered
    // together and PAD never sees an enable from one cycle with data from another.
    typedef struct packed {
        logic oe;
        logic dat;
    } drive_t;

    // Some configurations leave clk, rst_n, I or OE without a load; fold them
    // into one explicitly unused net so every configuration lints cleanly.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, core.I, core.OE, PAD};

    // ------------------------------------------------------------------
    // Core-to-pad driver
    // ------------------------------------------------------------------
    generate
        if (OUTPUT_USED) begin : g_out
            drive_t drv_d;
            drive_t drv_q;

            assign drv_d = '{oe: core.OE, dat: core.I};

            if (OUTPUT_REG) begin : g_reg
                // Sample the {OE, I} pair on each rising edge; reset releases the pad.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        // NOTE: clocked state uses non-blocking assignments so every
                        // flop samples its inputs as they were before the edge.
                        drv_q <= '{oe: 1'b0, dat: 1'b0};
                    end else begin
                        drv_q <= drv_d;
                    end
                end
            end else begin : g_comb
                assign drv_q = drv_d;
            end

            assign PAD = drv_q.oe ? drv_q.dat : 1'bz;
        end else begin : g_no_out
            assign PAD = 1'bz;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pad-to-core path (reads the resolved pad, so a driven pad loops back)
    // ------------------------------------------------------------------
    generate
        if (INPUT_USED) begin : g_in
            logic pad_s;

`ifdef GENERIC_IOB_SYNC_EN
            logic [1:0] sync_q;

            // Two-flop synchroniser: the pad level is asynchronous to clk.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= {2{IN_RST_VAL}};
                end else begin
                    sync_q <= {sync_q[0], PAD};
                end
            end

            assign pad_s = sync_q[1];
`else
            assign pad_s = PAD;
`endif

            if (INPUT_REG) begin : g_reg
                logic in_q;

                // Capture the (possibly synchronised) pad level once per cycle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        in_q <= IN_RST_VAL;
                    end else begin
                        in_q <= pad_s;
                    end
                end

                assign core.O = in_q;
            end else begin : g_comb
                assign core.O = pad_s;
            end
        end else begin : g_no_in
            assign core.O = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_generic_iob.sv
// tb_generic_iob: five generic_iob configurations on a shared clock/reset.
// Stimulus pushes hand-computed expectations into a queue; a monitor process
// pops and compares each one against the observed pad or core signal.
module tb_generic_iob;

`ifdef GENERIC_IOB_SYNC_EN
    localparam int SYNC = 1;
`else
    localparam int SYNC = 0;
`endif
    localparam int L_DEF  = 2 * SYNC;      // input latency, INPUT_REG=0
    localparam int L_IREG = 1 + 2 * SYNC;  // input latency, INPUT_REG=1

    typedef enum int {DEF = 0, OREG = 1, IREG = 2, NONE = 3, BOTH = 4} inst_e;

    typedef struct {
        string name;
        inst_e inst;
        bit    is_pad;
        logic  exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // External pad drivers (the "board" side of each pin)
    logic [4:0] ext_en;
    logic [4:0] ext_val;

    wire pad_def, pad_oreg, pad_ireg, pad_none, pad_both;
    assign pad_def  = ext_en[0] ? ext_val[0] : 1'bz;
    assign pad_oreg = ext_en[1] ? ext_val[1] : 1'bz;
    assign pad_ireg = ext_en[2] ? ext_val[2] : 1'bz;
    assign pad_none = ext_en[3] ? ext_val[3] : 1'bz;
    assign pad_both = ext_en[4] ? ext_val[4] : 1'bz;

    generic_iob_if if_def ();
    generic_iob_if if_oreg ();
    generic_iob_if if_ireg ();
    generic_iob_if if_none ();
    generic_iob_if if_both ();

    generic_iob u_def (
        .clk(clk), .rst_n(rst_n), .core(if_def), .PAD(pad_def)
    );

    generic_iob #(.OUTPUT_REG(1'b1)) u_oreg (
        .clk(clk), .rst_n(rst_n), .core(if_oreg), .PAD(pad_oreg)
    );

    generic_iob #(.INPUT_REG(1'b1), .IN_RST_VAL(1'b1)) u_ireg (
        .clk(clk), .rst_n(rst_n), .core(if_ireg), .PAD(pad_ireg)
    );

    generic_iob #(.INPUT_USED(1'b0), .OUTPUT_USED(1'b0)) u_none (
        .clk(clk), .rst_n(rst_n), .core(if_none), .PAD(pad_none)
    );

    generic_iob #(.INPUT_REG(1'b1), .OUTPUT_REG(1'b1)) u_both (
        .clk(clk), .rst_n(rst_n), .core(if_both), .PAD(pad_both)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    exp_t exp_q[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic observe(input inst_e inst, input bit is_pad);
        logic v;
        v = 1'bx;
        case (inst)
            DEF:  v = is_pad ? pad_def  : if_def.O;
            OREG: v = is_pad ? pad_oreg : if_oreg.O;
            IREG: v = is_pad ? pad_ireg : if_ireg.O;
            NONE: v = is_pad ? pad_none : if_none.O;
            BOTH: v = is_pad ? pad_both : if_both.O;
            default: v = 1'bx;
        endcase
        return v;
    endfunction

    task automatic expect_sig(input string name, input inst_e inst,
                              input bit is_pad, input logic exp);
        exp_t e;
        e.name   = name;
        e.inst   = inst;
        e.is_pad = is_pad;
        e.exp    = exp;
        exp_q.push_back(e);
        -> chk_ev;
        #1;
    endtask

    // Monitor: compare every queued expectation against the live DUT signal
    initial begin
        exp_t item;
        logic act;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                act  = observe(item.inst, item.is_pad);
                n_vec++;
                if (act !== item.exp) begin
                    n_err++;
                    $display("FAIL %s: observed %b, expected %b (t=%0t)",
                             item.name, act, item.exp, $time);
                end
            end
        end
    end

    // Wait out the input-path latency of an instance, then sample off-edge
    task automatic in_wait(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst_n   = 1'b1;
        ext_en  = 5'b0;
        ext_val = 5'b0;

        if_def.I  = 1'b0; if_def.OE  = 1'b0;
        if_oreg.I = 1'b1; if_oreg.OE = 1'b1;          // must stay off PAD in reset
        ext_en[OREG] = 1'b1; ext_val[OREG] = 1'b0;
        if_ireg.I = 1'b0; if_ireg.OE = 1'b0;
        ext_en[IREG] = 1'b1; ext_val[IREG] = 1'b1;    // idle-high line
        if_none.I = 1'b1; if_none.OE = 1'b1;          // must be ignored
        ext_en[NONE] = 1'b1; ext_val[NONE] = 1'b0;
        if_both.I = 1'b0; if_both.OE = 1'b1;

        #2 rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_sig("rst_ireg_o_rstval", IREG, 1'b0, 1'b1);
        expect_sig("rst_oreg_pad_z",    OREG, 1'b1, 1'b0);
        expect_sig("rst_both_o",        BOTH, 1'b0, 1'b0);

        if_oreg.I = 1'b0; if_oreg.OE = 1'b0;
        ext_en[OREG] = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;

        // Both paths absent: PAD never driven, O constant 0
        #1;
        expect_sig("none_pad_z", NONE, 1'b1, 1'b0);
        ext_val[NONE] = 1'b1;
        #1;
        expect_sig("none_o_const0", NONE, 1'b0, 1'b0);

        // Default configuration: combinational drive and loopback
        @(negedge clk);
        if_def.OE = 1'b1; if_def.I = 1'b0;
        #1;
        expect_sig("def_pad_drive0", DEF, 1'b1, 1'b0);
        in_wait(L_DEF);
        expect_sig("def_o_loop0", DEF, 1'b0, 1'b0);

        @(negedge clk);
        if_def.I = 1'b1;
        #1;
        expect_sig("def_pad_drive1", DEF, 1'b1, 1'b1);
        in_wait(L_DEF);
        expect_sig("def_o_loop1", DEF, 1'b0, 1'b1);

        @(negedge clk);
        if_def.OE = 1'b0;
        ext_en[DEF] = 1'b1; ext_val[DEF] = 1'b0;
        #1;
        expect_sig("def_pad_released", DEF, 1'b1, 1'b0);
        in_wait(L_DEF);
        expect_sig("def_o_ext0", DEF, 1'b0, 1'b0);

        @(negedge clk);
        ext_val[DEF] = 1'b1;
        #1;
        in_wait(L_DEF);
        expect_sig("def_o_ext1", DEF, 1'b0, 1'b1);

        // Registered input with idle-high reset value
        repeat (L_IREG) @(posedge clk);
        @(negedge clk);
        expect_sig("ireg_o_idle_high", IREG, 1'b0, 1'b1);
        ext_val[IREG] = 1'b0;
        #1;
        expect_sig("ireg_o_before_edge", IREG, 1'b0, 1'b1);
        for (int k = 1; k <= L_IREG; k++) begin
            @(posedge clk);
            #1;
            expect_sig("ireg_o_after_edge", IREG, 1'b0, (k == L_IREG) ? 1'b0 : 1'b1);
        end

        // Registered output and input: loopback one input latency later
        repeat (L_IREG + 1) @(posedge clk);
        @(negedge clk);
        expect_sig("both_pad_idle0", BOTH, 1'b1, 1'b0);
        expect_sig("both_o_idle0",   BOTH, 1'b0, 1'b0);
        if_both.I = 1'b1;
        #1;
        expect_sig("both_pad_before_edge", BOTH, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        expect_sig("both_pad_after_edge", BOTH, 1'b1, 1'b1);
        expect_sig("both_o_at_edge_n",    BOTH, 1'b0, 1'b0);
        for (int k = 1; k <= L_IREG; k++) begin
            @(posedge clk);
            #1;
            expect_sig("both_o_loopback", BOTH, 1'b0, (k == L_IREG) ? 1'b1 : 1'b0);
        end

        // Registered output, then asynchronous reset mid-cycle
        @(negedge clk);
        if_oreg.I = 1'b1; if_oreg.OE = 1'b1;
        ext_en[OREG] = 1'b1; ext_val[OREG] = 1'b0;
        #1;
        expect_sig("oreg_pad_z_before_edge", OREG, 1'b1, 1'b0);
        @(posedge clk);
        ext_en[OREG] = 1'b0;
        #1;
        expect_sig("oreg_pad_after_edge", OREG, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        ext_en[OREG] = 1'b1; ext_val[OREG] = 1'b0;
        #1;
        expect_sig("oreg_pad_z_async_rst", OREG, 1'b1, 1'b0);
        expect_sig("ireg_o_async_rst",     IREG, 1'b0, 1'b1);
        expect_sig("both_o_async_rst",     BOTH, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: observed %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
